scroll_window: RTL
==================

SCROLL_WINDOW -- requirements
Module: scroll_window

Interface
REQ-001 The block SHALL have parameter CHAR_W, default 4, meaning bits per display character.
REQ-002 The block SHALL have parameter BUF_CHARS, default 21, meaning characters in the source buffer.
REQ-003 The block SHALL have parameter WIN_CHARS, default 8, meaning characters in the visible window; 1 <= WIN_CHARS <= BUF_CHARS.
REQ-004 The block SHALL have parameter DWELL, default 2, meaning step_tick count held at each marquee end (0 = no dwell).
REQ-005 The block SHALL define IDX_W = clog2(BUF_CHARS) and MAX_BASE = BUF_CHARS - WIN_CHARS as local values.
REQ-006 clk  input  1  single clock; all state changes on its rising edge.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 buf_data  input  BUF_CHARS*CHAR_W  source text; char i = buf_data[i*CHAR_W +: CHAR_W].
REQ-009 cursor  input  IDX_W  edit cursor char index.
REQ-010 mode  input  2  0 = home, 1 = follow, 2 = marquee, 3 = freeze.
REQ-011 step_tick  input  1  one-cycle marquee advance strobe.
REQ-012 win_data  output  WIN_CHARS*CHAR_W  registered window; win_data[j*CHAR_W +: CHAR_W] = char base+j.
REQ-013 win_base  output  IDX_W  registered index of window char 0.
REQ-014 cur_off  output  IDX_W  cursor minus base, valid when cur_vis = 1, else 0.
REQ-015 cur_vis  output  1  cursor lies within [base, base+WIN_CHARS-1].
REQ-016 wrap_pulse  output  1  one-cycle pulse when the marquee returns from MAX_BASE to 0.

Function
REQ-017 The state machine SHALL have the states HOME, FOLLOW, MARQ_RUN, MARQ_DWELL and FROZEN; mode is sampled every cycle: 0->HOME, 1->FOLLOW, 3->FROZEN, 2->MARQ_RUN unless already in MARQ_RUN/MARQ_DWELL.
REQ-018 A cursor value >= BUF_CHARS SHALL be clamped to BUF_CHARS-1 before all use.
REQ-019 In HOME, base SHALL be set to 0 on the next edge.
REQ-020 In FOLLOW, if cursor > base+WIN_CHARS-1, base SHALL become cursor-WIN_CHARS+1; if cursor < base, base SHALL become cursor; otherwise base SHALL hold.
REQ-021 On entry to FOLLOW from any state, the rule in REQ-020 SHALL be applied on the first cycle, so the cursor is visible by the second edge.
REQ-022 On entry to MARQ_RUN, marquee SHALL continue from the current base with the dwell counter cleared.
REQ-023 In MARQ_RUN, on step_tick with base < MAX_BASE, base SHALL increment by 1; on step_tick with base == MAX_BASE, the block SHALL go to MARQ_DWELL if DWELL > 0, else base SHALL become 0 and wrap_pulse SHALL be 1 the following cycle.
REQ-024 In MARQ_DWELL, the block SHALL count step_ticks; on the DWELL-th tick, base SHALL become 0, wrap_pulse SHALL fire once, and the state SHALL return to MARQ_RUN.
REQ-025 If MAX_BASE == 0, marquee SHALL keep base at 0 and SHALL never assert wrap_pulse.
REQ-026 In FROZEN, base SHALL hold; cur_off and cur_vis SHALL still track the cursor.
REQ-027 step_tick outside marquee states SHALL be ignored.
REQ-028 Latency: cursor/mode sampled at edge N SHALL give win_base at N+1 and win_data/cur_off/cur_vis at N+2, the latter computed from the registered base.
REQ-029 win_data SHALL reflect buf_data changes with 1-cycle latency even when base is unchanged.
REQ-030 base SHALL never exceed MAX_BASE; arithmetic SHALL be done at IDX_W+1 bits to avoid underflow.

Reset
REQ-031 On rst_n = 0, the block SHALL asynchronously force the state to HOME, base to 0, dwell counter to 0, win_data to 0, cur_off to 0, cur_vis to 0 and wrap_pulse to 0.
REQ-032 Reset asserted mid-marquee or mid-dwell SHALL abort without a wrap_pulse; after release, the block SHALL act on the mode present at the first edge.

Verification (defaults 4/21/8/2)
REQ-033 The bench SHALL cover: reset then mode=1, cursor=5 -> win_base=0, cur_off=5, cur_vis=1.
REQ-034 The bench SHALL cover: mode=1, cursor stepped 5->12 -> win_base=5, cur_off=7; cursor then 3 -> win_base=3, cur_off=0.
REQ-035 The bench SHALL cover: mode=1, cursor=25 -> clamped to 20, win_base=13, cur_off=7, win_data = chars 13..20.
REQ-036 The bench SHALL cover: mode=2 from base 0, 13 ticks -> base=13, then 2 dwell ticks -> base=0 with exactly one wrap_pulse.
REQ-037 The bench SHALL cover: mode=3 at base 7 with cursor moved to 2 -> base stays 7, cur_vis=0; then mode=0 -> base=0.
REQ-038 The bench SHALL cover: rst_n pulsed low in MARQ_DWELL -> all outputs 0 immediately, no wrap_pulse; and a WIN_CHARS=21 build in marquee -> base stays 0 with no pulses.

Source files
------------

// File: rtl/scroll_window.sv
// scroll_window: windowed view of a character buffer with home/follow/marquee/freeze scrolling.
//   clk, rst_n (async, active-low)
//   buf_data   : source text, char i at [i*CHAR_W +: CHAR_W]
//   cursor     : edit cursor index (clamped to BUF_CHARS-1)
//   mode       : 0 home, 1 follow, 2 marquee, 3 freeze
//   step_tick  : marquee advance strobe
//   win_data   : registered window, char j = buffer char base+j
//   win_base   : registered window base index
//   cur_off    : cursor - base when visible, else 0
//   cur_vis    : cursor lies inside the window
//   wrap_pulse : one-cycle pulse when the marquee returns to 0
module scroll_window #(
  parameter int CHAR_W    = 4,
  parameter int BUF_CHARS = 21,
  parameter int WIN_CHARS = 8,
  parameter int DWELL     = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [BUF_CHARS*CHAR_W-1:0]   buf_data,
  input  logic [$clog2(BUF_CHARS)-1:0]  cursor,
  input  logic [1:0]                    mode,
  input  logic                          step_tick,
  output logic [WIN_CHARS*CHAR_W-1:0]   win_data,
  output logic [$clog2(BUF_CHARS)-1:0]  win_base,
  output logic [$clog2(BUF_CHARS)-1:0]  cur_off,
  output logic                          cur_vis,
  output logic                          wrap_pulse
);
  localparam int IDX_W    = $clog2(BUF_CHARS);
  localparam int MAX_BASE = BUF_CHARS - WIN_CHARS;
  localparam int DW       = DWELL > 1 ? $clog2(DWELL) : 1;
  localparam int WIN_W    = WIN_CHARS * CHAR_W;
  localparam logic [IDX_W:0]  BUF_M1 = (IDX_W+1)'(BUF_CHARS - 1);
  localparam logic [IDX_W:0]  WIN_M1 = (IDX_W+1)'(WIN_CHARS - 1);
  localparam logic [IDX_W:0]  MAXB   = (IDX_W+1)'(MAX_BASE);
  localparam logic [DW-1:0]   DWL_M1 = DW'(DWELL > 0 ? DWELL - 1 : 0);

  typedef enum logic [2:0] {HOME, FOLLOW, MARQ_RUN, MARQ_DWELL, FROZEN} state_t;

  state_t             state_q, state_d, eff;
  logic [IDX_W-1:0]   base_q, base_d, cur_q, cc;
  logic [IDX_W:0]     cw, bw, cqw;
  logic [DW-1:0]      dwell_q, dwell_d;
  logic               wrap_d, vis;
  logic [WIN_W-1:0]   win_q;
  logic [IDX_W-1:0]   off_q;
  logic               vis_q, wrap_q;

  assign cc  = ({1'b0, cursor} > BUF_M1) ? BUF_M1[IDX_W-1:0] : cursor;
  assign cw  = {1'b0, cc};
  assign bw  = {1'b0, base_q};
  assign cqw = {1'b0, cur_q};
  assign vis = (cqw >= bw) && (cqw <= bw + WIN_M1);
  // Mode takes effect in the cycle it is seen, so the first cycle in a state already applies its rule.
  assign eff = mode == 2'd0 ? HOME : mode == 2'd1 ? FOLLOW : mode == 2'd3 ? FROZEN :
               (state_q == MARQ_DWELL ? MARQ_DWELL : MARQ_RUN);

  always_comb begin
    state_d = eff;
    base_d  = base_q;
    dwell_d = '0;
    wrap_d  = 1'b0;
    case (eff)
      HOME: base_d = '0;
      FOLLOW: begin
        if (cw > bw + WIN_M1) base_d = IDX_W'(cw - WIN_M1);
        else if (cw < bw) base_d = cc;
      end
      MARQ_RUN: begin
        // A buffer no wider than the window has nowhere to scroll.
        if (step_tick && MAX_BASE > 0) begin
          if (bw < MAXB) base_d = base_q + 1'b1;
          else if (DWELL > 0) state_d = MARQ_DWELL;
          else begin
            base_d = '0;
            wrap_d = 1'b1;
          end
        end
      end
      MARQ_DWELL: begin
        dwell_d = dwell_q;
        if (step_tick) begin
          if (dwell_q == DWL_M1) begin
            base_d  = '0;
            wrap_d  = 1'b1;
            state_d = MARQ_RUN;
            dwell_d = '0;
          end else dwell_d = dwell_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HOME;
      base_q  <= '0;
      dwell_q <= '0;
      cur_q   <= '0;
      win_q   <= '0;
      off_q   <= '0;
      vis_q   <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      dwell_q <= dwell_d;
      cur_q   <= cc;
      win_q   <= WIN_W'(buf_data >> (base_q * CHAR_W));
      off_q   <= vis ? IDX_W'(cqw - bw) : '0;
      vis_q   <= vis;
      wrap_q  <= wrap_d;
    end
  end

  assign win_data   = win_q;
  assign win_base   = base_q;
  assign cur_off    = off_q;
  assign cur_vis    = vis_q;
  assign wrap_pulse = wrap_q;
endmodule
